gf180mcu_fd_sc_mcu9t5v0__bufz_rx: RTL



---
 rtl/gf180mcu_fd_sc_mcu9t5v0__bufz_rx.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__bufz_rx.sv
// Receive-side qualifier for a shared bufz bus: settles a one-hot driver, captures and tracks BUS, flags float/contention.
// Optional macro GF180MCU_FD_SC_MCU9T5V0__BUFZ_RX_KEEPER_EN retains Q/SRC through IDLE and CONTEND.
module gf180mcu_fd_sc_mcu9t5v0__bufz_rx #(
    parameter int WIDTH  = 8,
    parameter int NDRV   = 4,
    parameter int SETTLE = 2,
    parameter int CNT_W  = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NDRV-1:0]          EN,
    input  logic [WIDTH-1:0]         BUS,
    input  logic                     CLR,
    output logic [WIDTH-1:0]         Q,
    output logic                     QV,
    output logic [$clog2(NDRV)-1:0]  SRC,
    output logic                     FLOAT,
    output logic                     CONT,
    output logic [CNT_W-1:0]         CONT_CNT
);

    localparam int SRC_W = $clog2(NDRV);
    localparam int CW    = $clog2(SETTLE + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_HOLD    = 2'd2,
        S_CONTEND = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [SRC_W-1:0]   trk_q, trk_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               qv_q, qv_d;
    logic [SRC_W-1:0]   src_q, src_d;
    logic               float_q, float_d;
    logic               cont_q, cont_d;
    logic [CNT_W-1:0]   cc_q, cc_d;

    logic               none, multi;
    logic [SRC_W-1:0]   drv;
    logic               capture, track, entry, drop_q;

    // x & (x-1) is nonzero exactly when two or more enables are set.
    always_comb begin
        none  = (EN == '0);
        multi = ((EN & (EN - NDRV'(1))) != '0);
        drv   = '0;
        for (int i = 0; i < NDRV; i++) begin
            if (EN[i]) drv = SRC_W'(i);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            trk_q   <= '0;
            q_q     <= '0;
            qv_q    <= 1'b0;
            src_q   <= '0;
            float_q <= 1'b1;
            cont_q  <= 1'b0;
            cc_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            trk_q   <= trk_d;
            q_q     <= q_d;
            qv_q    <= qv_d;
            src_q   <= src_d;
            float_q <= float_d;
            cont_q  <= cont_d;
            cc_q    <= cc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        trk_d   = trk_q;
        capture = 1'b0;
        track   = 1'b0;
        if (none) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (multi) begin
            state_d = S_CONTEND;
            cnt_d   = '0;
        end else if (state_q == S_HOLD && drv == trk_q) begin
            track = 1'b1;
        end else begin
            // Any change of driver, or arriving from a non-SETTLE state, restarts the count.
            cnt_d = (state_q == S_SETTLE && drv == trk_q) ? cnt_q + CW'(1) : CW'(1);
            trk_d = drv;
            if (cnt_d == CW'(SETTLE)) begin
                capture = 1'b1;
                state_d = S_HOLD;
            end else begin
                state_d = S_SETTLE;
            end
        end
    end

`ifdef GF180MCU_FD_SC_MCU9T5V0__BUFZ_RX_KEEPER_EN
    assign drop_q = 1'b0;
`else
    assign drop_q = none | multi;
`endif

    always_comb begin
        q_d     = q_q;
        qv_d    = 1'b0;
        src_d   = src_q;
        float_d = none;
        cont_d  = cont_q;
        cc_d    = cc_q;
        entry   = multi && (state_q != S_CONTEND);
        if (capture) begin
            q_d   = BUS;
            src_d = drv;
            qv_d  = 1'b1;
        end else if (track) begin
            q_d  = BUS;
            qv_d = (BUS != q_q);
        end
        if (drop_q) begin
            q_d   = '0;
            src_d = '0;
        end
        if (multi) begin
            cont_d = 1'b1;
        end else if (CLR) begin
            cont_d = 1'b0;
        end
        // A contention entry coinciding with CLR restarts the count at one.
        if (entry) begin
            if (CLR) cc_d = CNT_W'(1);
            else if (cc_q != '1) cc_d = cc_q + CNT_W'(1);
        end else if (CLR) begin
            cc_d = '0;
        end
    end

    assign Q        = q_q;
    assign QV       = qv_q;
    assign SRC      = src_q;
    assign FLOAT    = float_q;
    assign CONT     = cont_q;
    assign CONT_CNT = cc_q;

endmodule
